// File: rtl/bellman_pkg.sv
// Shared state codes, phase groupings and guard defaults for the Bellman-Ford sequencer.
// State codes 0-20 are the datapath's case selectors and must not be renumbered.
package bellman_pkg;

  localparam logic [4:0] S_IDLE = 5'd0;
  localparam logic [4:0] S_1    = 5'd1;
  localparam logic [4:0] S_2    = 5'd2;
  localparam logic [4:0] S_3    = 5'd3;
  localparam logic [4:0] S_4    = 5'd4;
  localparam logic [4:0] S_5    = 5'd5;
  localparam logic [4:0] S_6    = 5'd6;
  localparam logic [4:0] S_7    = 5'd7;
  localparam logic [4:0] S_8    = 5'd8;
  localparam logic [4:0] S_9    = 5'd9;
  localparam logic [4:0] S_10   = 5'd10;
  localparam logic [4:0] S_11   = 5'd11;
  localparam logic [4:0] S_12   = 5'd12;
  localparam logic [4:0] S_13   = 5'd13;
  localparam logic [4:0] S_14   = 5'd14;
  localparam logic [4:0] S_15   = 5'd15;
  localparam logic [4:0] S_16   = 5'd16;
  localparam logic [4:0] S_17   = 5'd17;
  localparam logic [4:0] S_18   = 5'd18;
  localparam logic [4:0] S_19   = 5'd19;
  localparam logic [4:0] S_END  = 5'd20;

  localparam int          WDOG_W_DEF     = 16;
  localparam logic [15:0] WDOG_LIMIT_DEF = 16'd4096;
  localparam logic [7:0]  MAX_HOPS_DEF   = 8'd255;

  typedef enum logic [2:0] {PH_IDLE, PH_INPUT, PH_INIT, PH_RELAX, PH_OUTPUT, PH_DONE} phase_t;
  typedef enum logic [1:0] {ABORT_NONE, ABORT_WDOG, ABORT_HOP} abort_cause_t;

  // S13 is the abort/negative-cycle exit and still counts as relaxation work.
  function automatic phase_t phaseOf(logic [4:0] s);
    if (s == S_IDLE)                              return PH_IDLE;
    if (s <= S_4)                                 return PH_INPUT;
    if (s == S_5)                                 return PH_INIT;
    if ((s >= S_6 && s <= S_11) || s == S_13)     return PH_RELAX;
    if (s == S_12 || (s >= S_14 && s <= S_19))    return PH_OUTPUT;
    return PH_DONE;
  endfunction

  function automatic logic isWaitState(logic [4:0] s);
    return (s == S_5) || (s == S_10);
  endfunction

endpackage

// File: rtl/bellman_guard.sv
// Watchdog and predecessor-hop counters; raises a combinational abort request from registered counts.
// Counters update every cycle; no handshake, the sequencer acts on abortReq in the same cycle.
module bellman_guard
  import bellman_pkg::*;
#(
  parameter int                WDOG_W     = WDOG_W_DEF,
  parameter logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(WDOG_LIMIT_DEF),
  parameter logic [7:0]        MAX_HOPS   = MAX_HOPS_DEF
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [4:0]   state,
  input  logic         outputWriteDone,
  output logic         abortReq,
  output abort_cause_t abortCause
);

  logic [WDOG_W-1:0] wdog;
  logic [7:0]        hop;
  logic              inWait;
  logic              wdogTrip;
  logic              hopTrip;

  assign inWait   = isWaitState(state);
  assign wdogTrip = inWait && (wdog == WDOG_LIMIT - WDOG_W'(1));
  assign hopTrip  = (state == S_18) && (hop == MAX_HOPS) && !outputWriteDone;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wdog <= '0;
      hop  <= '0;
    end else begin
      if (!inWait)
        wdog <= '0;
      else if (wdog != '1)
        wdog <= wdog + WDOG_W'(1);

      // A step back to S17 happens exactly when S18 neither finishes nor trips.
      if (state == S_12)
        hop <= '0;
      else if (state == S_18 && !outputWriteDone && hop != MAX_HOPS)
        hop <= hop + 8'd1;
    end
  end

  always_comb begin
    abortReq   = wdogTrip || hopTrip;
    abortCause = ABORT_NONE;
    if (wdogTrip)
      abortCause = ABORT_WDOG;
    else if (hopTrip)
      abortCause = ABORT_HOP;
  end

endmodule

// File: rtl/bellman_ctrl.sv
// Bellman-Ford sequencing FSM: one transition per clock, all outputs registered (new code visible next cycle).
// No backpressure; start is only honoured in IDLE or S20, guard aborts divert to S13.
module bellman_ctrl
  import bellman_pkg::*;
#(
  parameter int                WDOG_W     = WDOG_W_DEF,
  parameter logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(WDOG_LIMIT_DEF),
  parameter logic [7:0]        MAX_HOPS   = MAX_HOPS_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       iterDone,
  input  logic       negCycle,
  input  logic       zeroFlag,
  input  logic       outputWriteDone,
  input  logic       goS8,
  input  logic       graphData1_Zero_reg,
  input  logic       iterStop,
  output logic [4:0] state,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] query_count
);

  logic [4:0]   nextState;
  logic         illegal;
  logic         abortReq;
  abort_cause_t abortCause;
  logic         abortHit;
  logic         startTaken;
  logic         nextBusy;
  logic         nextDone;
  logic         nextError;
  logic [7:0]   nextQueryCount;
  phase_t       nextPhase;

  bellman_guard #(
    .WDOG_W     (WDOG_W),
    .WDOG_LIMIT (WDOG_LIMIT),
    .MAX_HOPS   (MAX_HOPS)
  ) u_guard (
    .clock           (clock),
    .reset           (reset),
    .state           (state),
    .outputWriteDone (outputWriteDone),
    .abortReq        (abortReq),
    .abortCause      (abortCause)
  );

  assign abortHit   = abortReq && (abortCause != ABORT_NONE);
  assign startTaken = start && (state == S_IDLE || state == S_END);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      state <= S_IDLE;
    else
      state <= nextState;
  end

  always_comb begin
    nextState = state;
    illegal   = 1'b0;
    case (state)
      S_IDLE: if (start) nextState = S_1;
      S_1:    nextState = S_2;
      S_2:    nextState = S_3;
      S_3:    nextState = S_4;
      S_4:    nextState = S_5;
      S_5:    if (graphData1_Zero_reg) nextState = S_6;
      S_6:    nextState = S_7;
      S_7:    nextState = S_8;
      S_8:    nextState = S_9;
      S_9:    nextState = S_10;
      S_10: begin
        if (iterDone)  nextState = S_11;
        else if (goS8) nextState = S_8;
      end
      S_11: begin
        if (negCycle)      nextState = S_13;
        else if (iterStop) nextState = S_12;
        else               nextState = S_6;
      end
      S_12:  nextState = S_14;
      S_13:  nextState = S_END;
      S_14:  nextState = S_15;
      S_15:  nextState = S_16;
      S_16:  nextState = S_17;
      S_17:  nextState = S_18;
      S_18:  nextState = outputWriteDone ? S_19 : S_17;
      S_19:  nextState = zeroFlag ? S_END : S_1;
      S_END: if (start) nextState = S_1;
      default: begin
        nextState = S_END;
        illegal   = 1'b1;
      end
    endcase
    if (!illegal && abortHit)
      nextState = S_13;
  end

  always_comb begin
    nextPhase      = phaseOf(nextState);
    nextBusy       = !(nextPhase == PH_IDLE || nextPhase == PH_DONE);
    nextDone       = (nextState == S_END);
    nextError      = error;
    nextQueryCount = query_count;
    if (startTaken) begin
      nextError      = 1'b0;
      nextQueryCount = 8'd0;
    end
    if (state == S_19)
      nextQueryCount = query_count + 8'd1;
    if (illegal || abortHit)
      nextError = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      query_count <= 8'd0;
    end else begin
      busy        <= nextBusy;
      done        <= nextDone;
      error       <= nextError;
      query_count <= nextQueryCount;
    end
  end

endmodule

// File: tb/tb_bellman_ctrl.sv
// Randomized bench for bellman_ctrl: a behavioural model queues expected outputs, a monitor checks them.
// Uses a small watchdog limit and hop limit so both guard aborts occur often.
module tb_bellman_ctrl;

  localparam int WLIM = 16;
  localparam int MAXH = 3;
  localparam int NCYC = 20000;

  logic       clock = 1'b0;
  logic       reset;
  logic       start, iterDone, negCycle, zeroFlag, outputWriteDone, goS8, graphData1_Zero_reg, iterStop;
  logic [4:0] state;
  logic       busy, done, error;
  logic [7:0] query_count;

  typedef struct {
    int st;
    bit busy;
    bit done;
    bit err;
    int qc;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: the phase code, how long we've been waiting, how many
  // predecessor hops this query walked, sticky error and completed-query tally.
  int mS, waitCycles, hopsWalked, mQc, runQueries;
  bit mErr;
  int mode;
  bit firstRun = 1'b1;
  bit didReset = 1'b0;

  bellman_ctrl #(
    .WDOG_W     (16),
    .WDOG_LIMIT (16'(WLIM)),
    .MAX_HOPS   (8'(MAXH))
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .start               (start),
    .iterDone            (iterDone),
    .negCycle            (negCycle),
    .zeroFlag            (zeroFlag),
    .outputWriteDone     (outputWriteDone),
    .goS8                (goS8),
    .graphData1_Zero_reg (graphData1_Zero_reg),
    .iterStop            (iterStop),
    .state               (state),
    .busy                (busy),
    .done                (done),
    .error               (error),
    .query_count         (query_count)
  );

  always #5 clock = ~clock;

  function automatic int normalNext(int s);
    case (s)
      0:       return start ? 1 : 0;
      4:       return 5;
      5:       return graphData1_Zero_reg ? 6 : 5;
      10:      return iterDone ? 11 : (goS8 ? 8 : 10);
      11:      return negCycle ? 13 : (iterStop ? 12 : 6);
      12:      return 14;
      13:      return 20;
      18:      return outputWriteDone ? 19 : 17;
      19:      return zeroFlag ? 20 : 1;
      20:      return start ? 1 : 20;
      default: return s + 1;
    endcase
  endfunction

  task automatic modelReset();
    mS = 0; waitCycles = 0; hopsWalked = 0; mQc = 0; mErr = 0; runQueries = 0;
  endtask

  task automatic modelStep();
    int   ns;
    bit   waiting;
    exp_t e;
    waiting = (mS == 5 || mS == 10);
    ns = normalNext(mS);
    if (waiting && waitCycles == WLIM - 1) begin
      ns = 13; mErr = 1;
    end else if (mS == 18 && hopsWalked == MAXH && !outputWriteDone) begin
      ns = 13; mErr = 1;
    end
    if ((mS == 0 || mS == 20) && start) begin
      mErr = 0; mQc = 0; runQueries = 0;
    end
    if (mS == 19) begin
      mQc = (mQc + 1) % 256;
      runQueries++;
    end
    waitCycles = waiting ? waitCycles + 1 : 0;
    if (mS == 12) hopsWalked = 0;
    else if (mS == 18 && ns == 17) hopsWalked++;
    mS = ns;
    e.st = mS; e.busy = !(mS == 0 || mS == 20); e.done = (mS == 20); e.err = mErr; e.qc = mQc;
    expQ.push_back(e);
  endtask

  function automatic bit pct(int p);
    return $urandom_range(0, 99) < p;
  endfunction

  task automatic driveRandom();
    int pGz = 40, pIter = 10, pGo = 25, pNeg = 8, pStop = 40, pOwd = 40, pZf = 50;
    case (mode)
      1: begin pIter = 0; pGo = 0; end
      2: pGz = 0;
      3: pOwd = 0;
      4: pNeg = 90;
      5: begin
        pGz = 100; pIter = 100; pNeg = 0; pStop = 100; pOwd = 100;
        pZf = (runQueries >= 258) ? 100 : 0;
      end
      default: ;
    endcase
    start               = (mS == 0 || mS == 20) ? pct(40) : pct(3);
    graphData1_Zero_reg = pct(pGz);
    iterDone            = pct(pIter);
    goS8                = pct(pGo);
    negCycle            = pct(pNeg);
    iterStop            = pct(pStop);
    outputWriteDone     = pct(pOwd);
    zeroFlag            = pct(pZf);
    if (start && (mS == 0 || mS == 20)) begin
      mode = firstRun ? 5 : int'($urandom_range(0, 4));
      firstRun = 1'b0;
    end
  endtask

  task automatic checkZeroNow(string name);
    checks++;
    if (state !== 5'd0 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || query_count !== 8'd0) begin
      errors++;
      $display("FAIL %s: got state=%0d busy=%0b done=%0b error=%0b qc=%0d, want all zero",
               name, state, busy, done, error, query_count);
    end
  endtask

  // Monitor: every cycle the DUT presents a fresh registered output, so pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checks++;
        if (state !== 5'(e.st) || busy !== e.busy || done !== e.done || error !== e.err ||
            query_count !== 8'(e.qc)) begin
          errors++;
          $display("FAIL step t=%0t: got state=%0d busy=%0b done=%0b error=%0b qc=%0d, want state=%0d busy=%0b done=%0b error=%0b qc=%0d",
                   $time, state, busy, done, error, query_count, e.st, e.busy, e.done, e.err, e.qc);
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    start = 0; iterDone = 0; negCycle = 0; zeroFlag = 0; outputWriteDone = 0;
    goS8 = 0; graphData1_Zero_reg = 0; iterStop = 0;
    mode = 0;
    modelReset();
    #1;
    checkZeroNow("reset_values");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clock);
      if (!didReset && cyc > 8000 && mS == 10) begin
        start = 1'b0;
        #2 reset = 1'b0;
        #1;
        checkZeroNow("async_reset_mid_s10");
        modelReset();
        @(negedge clock);
        reset = 1'b1;
        didReset = 1'b1;
        continue;
      end
      driveRandom();
      modelStep();
    end

    @(negedge clock);
    @(negedge clock);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bellman_ctrl.md
Name: bellman_ctrl

Overview:
Sequencing FSM for the Bellman-Ford datapath. It drives the 5-bit state code that selects the datapath's per-cycle action, and advances on the datapath's status flags through four phases: input (source/destination pair load), initialization, relaxation iterations, and output path write-back. It also provides the start/done handshake to the top level, plus watchdog and path-hop guards that abort hung runs.

Parameters:
WDOG_LIMIT, 16'd4096, max consecutive cycles allowed in S5 or S10 before abort
MAX_HOPS, 8'd255, max predecessor hops walked in output phase before abort
WDOG_W, 16, watchdog counter width

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; begins a run from IDLE or S20
iterDone  input  1  last daughter of last vertex in current iteration
negCycle  input  1  final iteration still updating
zeroFlag  input  1  00 terminator read; no more src/dst pairs
outputWriteDone  input  1  current predecessor equals source
goS8  input  1  current Graph SRAM line exhausted; fetch next line
graphData1_Zero_reg  input  1  vertex list terminator reached
iterStop  input  1  no relaxation update this iteration
state  output  5  registered state code to datapath
busy  output  1  high in every state except IDLE and S20
done  output  1  high in S20
error  output  1  sticky abort flag (watchdog or hop limit)
query_count  output  8  number of completed src/dst pairs this run

Behaviour:
- Reset is asynchronous and active-low. On reset: state=0 (IDLE), busy=0, done=0, error=0, query_count=0, all counters 0. A mid-run reset returns to IDLE immediately; no output persists.
- All outputs are registered. There is exactly one transition per clock, and the datapath sees the new code on the cycle after the decision.
- Transitions:
  - IDLE(0): on start -> S1; otherwise stay.
  - Input phase: S1 -> S2 -> S3 -> S4.
  - Initialization: S4 -> S5. S5 stays while graphData1_Zero_reg=0 and goes to S6 when it is 1.
  - Relaxation: S6 -> S7 -> S8 -> S9 -> S10. In S10: iterDone -> S11; else goS8 -> S8; else stay. iterDone has priority over goS8.
  - S11: negCycle -> S13; else iterStop=1 -> S12; else -> S6. negCycle has priority.
  - Output phase: S12 -> S14 -> S15 -> S16 -> S17 -> S18. In S18: outputWriteDone -> S19; else -> S17.
  - S19: zeroFlag=1 -> S20; else -> S1. query_count increments on the S19 exit.
  - S13 -> S20.
  - S20: hold, done=1. start -> S1, which clears error and query_count.
  - Codes 21-31 are illegal and go to S20 with error=1.
- start outside IDLE/S20 is ignored.
- Watchdog:
  - wdog increments each cycle the FSM stays in S5 or S10 and clears on any other state.
  - When wdog reaches WDOG_LIMIT-1 while still in S5/S10, the next state is S13 and error=1.
  - Saturates; never wraps.
- Hop guard:
  - hop clears in S12 and increments on each S18 -> S17 transition.
  - If hop==MAX_HOPS in S18 and outputWriteDone=0, next state is S13 and error=1.
- Abort priority over normal transitions in the same cycle: reset > illegal code > watchdog/hop abort > normal.
- query_count wraps 255 -> 0.
- error clears only on reset or start from S20.

Decomposition:
- Shared package bellman_pkg holds:
  - S_IDLE..S_END localparams, 5-bit, values 0-20 matching datapath case codes.
  - Phase groupings.
  - WDOG_LIMIT/MAX_HOPS defaults.
- One natural sub-module: bellman_guard, which holds the wdog and hop counters and produces a single abort_req plus cause.
- Next-state logic and the state register stay in bellman_ctrl.

Test Plan:
- reset=0 mid-S10 (state=10) -> state=0, busy=0, error=0 asynchronously, before the next clock edge.
- start pulse, graphData1_Zero_reg=1 on 3rd S5 cycle, goS8 every 4 cycles in S10, iterDone after 20, iterStop=1 in S11 -> sequence reaches S12, S14..S18.
- S11 with negCycle=1 and iterStop=0 simultaneously -> S13 then S20, done=1, error=0.
- Output walk: outputWriteDone=0 for 2 S18 visits then 1, zeroFlag=0 -> S17,S18,S17,S18,S17,S18,S19,S1; query_count=1.
- Hold in S10 with iterDone=goS8=0 and WDOG_LIMIT=16 -> S13 on 16th cycle, error=1, S20 next; start -> S1 with error=0.
- MAX_HOPS=3, outputWriteDone never asserted -> after 3 S18->S17 returns, S18 -> S13, error=1.
